// File: rtl/img_replay_sequencer.sv
// Captures one packed image into a word buffer, then replays it pixel-serially to the SNN
// core for a latched number of presentations, spacing presentations by a fixed idle gap.
`timescale 1ns/1ps

module img_replay_sequencer #(
    parameter int M       = 784,
    parameter int PIX_W   = 8,
    parameter int WORD_W  = 32,
    parameter int REP_W   = 4,
    parameter int LABEL_W = 8,
    parameter int GAP_CYC = 4,
    localparam int PPW    = WORD_W / PIX_W,
    localparam int NWORDS = M / PPW,
    localparam int AW     = $clog2(M),
    localparam int WA     = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int SW     = (PPW > 1) ? $clog2(PPW) : 1,
    localparam int GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start_main,
    input  logic [1:0]         i_mode_in,
    input  logic [LABEL_W-1:0] i_label_in,
    input  logic [REP_W-1:0]   i_repeat_in,
    input  logic [WORD_W-1:0]  i_image_in,
    input  logic               i_valid_image,
    input  logic               i_valid_all,
    output logic               o_ready,
    output logic               o_start_core_img,
    output logic [PIX_W-1:0]   o_pix_out,
    output logic [AW-1:0]      o_pix_addr,
    output logic               o_pix_valid,
    output logic [1:0]         o_mode_out,
    output logic [LABEL_W-1:0] o_label_out,
    output logic [REP_W-1:0]   o_epoch,
    output logic               o_seq_done,
    output logic               o_err_proto
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PRESENT   = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_GAP       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_buf [NWORDS];
    logic [WA-1:0]       r_wcnt;
    logic [WA-1:0]       r_ridx;
    logic [SW-1:0]       r_slot;
    logic [AW-1:0]       r_paddr;
    logic [WORD_W-1:0]   r_word;
    logic [GW-1:0]       r_gcnt;
    logic [REP_W-1:0]    r_repeat;

    logic                w_buf_we;
    logic                w_last_ep;
    logic                w_launch;
    logic                w_err;

    // Decode buffer writes, the final presentation, presentation launch and protocol errors
    always_comb begin
        w_buf_we  = (r_state == S_LOAD) && i_valid_image;
        w_last_ep = ((o_epoch + REP_W'(1)) == r_repeat);
        w_launch  = (w_buf_we && (r_wcnt == WA'(NWORDS - 1)))
                 || ((GAP_CYC == 1) && (r_state == S_WAIT_CORE) && i_valid_all && !w_last_ep)
                 || ((GAP_CYC > 1) && (r_state == S_GAP) && (r_gcnt == GW'(GAP_CYC - 2)));
        w_err     = (i_start_main && (r_state != S_IDLE))
                 || (i_valid_image && ((r_state == S_PRESENT) || (r_state == S_WAIT_CORE)
                                       || (r_state == S_GAP)));
    end

    // Image word store; contents are only read after a complete load
    always_ff @(posedge i_clk) begin
        if (w_buf_we) begin
            r_buf[r_wcnt] <= i_image_in;
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_wcnt           <= {WA{1'b0}};
            r_ridx           <= {WA{1'b0}};
            r_slot           <= {SW{1'b0}};
            r_paddr          <= {AW{1'b0}};
            r_word           <= {WORD_W{1'b0}};
            r_gcnt           <= {GW{1'b0}};
            r_repeat         <= {REP_W{1'b0}};
            o_ready          <= 1'b1;
            o_start_core_img <= 1'b0;
            o_pix_out        <= {PIX_W{1'b0}};
            o_pix_addr       <= {AW{1'b0}};
            o_pix_valid      <= 1'b0;
            o_mode_out       <= 2'b00;
            o_label_out      <= {LABEL_W{1'b0}};
            o_epoch          <= {REP_W{1'b0}};
            o_seq_done       <= 1'b0;
            o_err_proto      <= 1'b0;
        end else begin
            o_start_core_img <= 1'b0;
            o_pix_valid      <= 1'b0;
            o_seq_done       <= 1'b0;
            if (w_err) begin
                o_err_proto <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start_main) begin
                        o_mode_out  <= i_mode_in;
                        o_label_out <= i_label_in;
                        r_repeat    <= (i_repeat_in == {REP_W{1'b0}}) ? REP_W'(1) : i_repeat_in;
                        r_wcnt      <= {WA{1'b0}};
                        o_epoch     <= {REP_W{1'b0}};
                        o_ready     <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_valid_image) begin
                        if (r_wcnt == WA'(NWORDS - 1)) begin
                            r_state <= S_PRESENT;
                        end else begin
                            r_wcnt <= r_wcnt + WA'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    o_pix_valid <= 1'b1;
                    o_pix_addr  <= r_paddr;
                    o_pix_out   <= r_word[PIX_W-1:0];
                    // The next word is fetched as the last slot of the current one goes out
                    if (r_slot == SW'(PPW - 1)) begin
                        r_slot <= {SW{1'b0}};
                        r_word <= r_buf[r_ridx];
                        if (r_ridx != WA'(NWORDS - 1)) begin
                            r_ridx <= r_ridx + WA'(1);
                        end
                    end else begin
                        r_slot <= r_slot + SW'(1);
                        r_word <= r_word >> PIX_W;
                    end
                    if (r_paddr == AW'(M - 1)) begin
                        r_state <= S_WAIT_CORE;
                    end else begin
                        r_paddr <= r_paddr + AW'(1);
                    end
                end
                S_WAIT_CORE: begin
                    if (i_valid_all) begin
                        o_epoch <= o_epoch + REP_W'(1);
                        if (w_last_ep) begin
                            o_seq_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (GAP_CYC == 1) begin
                            r_state <= S_PRESENT;
                        end else begin
                            r_gcnt  <= {GW{1'b0}};
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_launch) begin
                        r_state <= S_PRESENT;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1);
                    end
                end
                S_DONE: begin
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase

            if (w_launch) begin
                o_start_core_img <= 1'b1;
                r_paddr          <= {AW{1'b0}};
                r_slot           <= {SW{1'b0}};
                r_ridx           <= WA'((NWORDS > 1) ? 1 : 0);
                r_word           <= r_buf[0];
            end
        end
    end

endmodule

// File: tb/tb_img_replay_sequencer.sv
// Randomized scoreboard bench for img_replay_sequencer: the stimulus process predicts every
// start/pixel/done event with its cycle number; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_img_replay_sequencer;
    localparam int M = 784, PIX_W = 8, WORD_W = 32, REP_W = 4, LABEL_W = 8, GAP_CYC = 4;
    localparam int PPW = WORD_W / PIX_W, NW = M / PPW, AW = $clog2(M);
    localparam int K_START = 1, K_PIX = 2, K_DONE = 3;

    logic clk = 1'b0, rst_n = 1'b0, start_main = 1'b0, valid_image = 1'b0, valid_all = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [LABEL_W-1:0] label_in = '0;
    logic [REP_W-1:0] repeat_in = '0;
    logic [WORD_W-1:0] image_in = '0;
    logic ready, start_core_img, pix_valid, seq_done, err_proto;
    logic [PIX_W-1:0] pix_out;
    logic [AW-1:0] pix_addr;
    logic [1:0] mode_out;
    logic [LABEL_W-1:0] label_out;
    logic [REP_W-1:0] epoch;

    img_replay_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_main(start_main), .i_mode_in(mode_in),
        .i_label_in(label_in), .i_repeat_in(repeat_in), .i_image_in(image_in),
        .i_valid_image(valid_image), .i_valid_all(valid_all), .o_ready(ready),
        .o_start_core_img(start_core_img), .o_pix_out(pix_out), .o_pix_addr(pix_addr),
        .o_pix_valid(pix_valid), .o_mode_out(mode_out), .o_label_out(label_out),
        .o_epoch(epoch), .o_seq_done(seq_done), .o_err_proto(err_proto)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int kind; int cyc; int addr; int data;} exp_t;
    exp_t exp_q[$];
    int n_vec = 0, n_bad = 0;
    bit mon_en = 1'b0;
    logic [PIX_W-1:0] img [M];

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int kind, input int c, input int addr, input int data);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed event must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        int k, a, d, nact;
        if (mon_en && (start_core_img || pix_valid || seq_done)) begin
            nact = int'(start_core_img) + int'(pix_valid) + int'(seq_done);
            k = start_core_img ? K_START : (pix_valid ? K_PIX : K_DONE);
            a = (k == K_PIX) ? int'(pix_addr) : 0;
            d = (k == K_PIX) ? int'(pix_out) : ((k == K_DONE) ? int'(epoch) : 0);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: cycle %0d kind %0d addr %0d data %0d, none expected",
                         cyc, k, a, d);
            end else begin
                e = exp_q.pop_front();
                if (nact != 1 || k != e.kind || cyc != e.cyc || a != e.addr || d != e.data) begin
                    n_bad++;
                    $display("FAIL event: got kind %0d cyc %0d addr %0d data %0d (n=%0d), expected kind %0d cyc %0d addr %0d data %0d",
                             k, cyc, a, d, nact, e.kind, e.cyc, e.addr, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ready", int'(ready), 1);
        check("rst_start", int'(start_core_img), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_seq_done", int'(seq_done), 0);
        check("rst_err", int'(err_proto), 0);
        check("rst_epoch", int'(epoch), 0);
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        tick();
    endtask

    // One capture + replay sequence; reset_at_pix >= 0 aborts the first presentation there
    task automatic run_seq(input int rep, input bit ramp, input bit stall, input bit inj_err,
                           input int reset_at_pix);
        int rep_eff, s_cyc, t_cyc;
        logic [1:0] md;
        logic [LABEL_W-1:0] lb;
        rep_eff = (rep == 0) ? 1 : rep;
        md = 2'($urandom);
        lb = LABEL_W'($urandom);
        for (int a = 0; a < M; a++) img[a] = ramp ? PIX_W'(a) : PIX_W'($urandom);

        valid_image = 1'b1; image_in = $urandom;
        tick();
        valid_image = 1'b0;
        check("idle_ready", int'(ready), 1);
        start_main = 1'b1; mode_in = md; label_in = lb; repeat_in = REP_W'(rep);
        tick();
        start_main = 1'b0; repeat_in = REP_W'($urandom); mode_in = 2'($urandom);
        check("load_ready", int'(ready), 0);
        check("mode_out", int'(mode_out), int'(md));
        check("label_out", int'(label_out), int'(lb));
        check("epoch_cleared", int'(epoch), 0);

        for (int w = 0; w < NW; w++) begin
            if (stall) begin
                valid_image = 1'b0;
                tick();
            end
            valid_image = 1'b1;
            for (int k = 0; k < PPW; k++) image_in[k*PIX_W +: PIX_W] = img[w*PPW + k];
            tick();
        end
        valid_image = 1'b0;
        s_cyc = cyc;

        for (int p = 0; p < rep_eff; p++) begin
            push(K_START, s_cyc, 0, 0);
            for (int a = 0; a < M; a++) push(K_PIX, s_cyc + 1 + a, a, int'(img[a]));
            if (reset_at_pix >= 0) begin
                goto_cycle(s_cyc + 1 + reset_at_pix);
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                exp_q.delete();
                check("abort_pix_valid", int'(pix_valid), 0);
                check("abort_ready", int'(ready), 1);
                check("abort_seq_done", int'(seq_done), 0);
                check("abort_err", int'(err_proto), 0);
                repeat (30) tick();
                return;
            end
            if (inj_err && p == 0) begin
                goto_cycle(s_cyc + 100);
                start_main = 1'b1; repeat_in = REP_W'(7);
                tick();
                start_main = 1'b0;
                goto_cycle(s_cyc + M + 1);
                valid_image = 1'b1; image_in = $urandom;
                tick();
                valid_image = 1'b0;
            end
            t_cyc = s_cyc + M + int'($urandom_range(5, 30));
            goto_cycle(t_cyc);
            valid_all = 1'b1;
            tick();
            valid_all = 1'b0;
            check("epoch_step", int'(epoch), p + 1);
            if (p < rep_eff - 1) begin
                s_cyc = t_cyc + GAP_CYC;
                if ($urandom_range(0, 1) == 1) begin
                    goto_cycle(t_cyc + 2);
                    valid_all = 1'b1;
                    tick();
                    valid_all = 1'b0;
                end
            end else begin
                push(K_DONE, t_cyc + 1, 0, rep_eff);
            end
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        check("done_ready", int'(ready), 1);
        check("done_epoch", int'(epoch), rep_eff);
        check("hold_mode", int'(mode_out), int'(md));
        check("hold_label", int'(label_out), int'(lb));
        check("err_flag", int'(err_proto), int'(inj_err));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        do_reset();
        run_seq(1, 1'b1, 1'b0, 1'b0, -1);
        run_seq(5, 1'b0, 1'b0, 1'b0, -1);
        run_seq(0, 1'b0, 1'b1, 1'b0, -1);
        run_seq(3, 1'b0, 1'b0, 1'b1, -1);
        check("err_sticky", int'(err_proto), 1);
        run_seq(2, 1'b0, 1'b0, 1'b0, 300);
        run_seq(3, 1'b0, 1'b1, 1'b0, -1);
        run_seq(int'($urandom_range(2, 4)), 1'b0, 1'b0, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
